// File: rtl/slc3_muldiv_unit.sv
// Multi-cycle signed multiply/divide engine for the SLC-3 MULT/DIV ALU ops.
// Optional macro SLC3_MULDIV_PRODHI_EN adds the ProdHi output (upper half of the product).
module slc3_muldiv_unit #(
    parameter int         WIDTH   = 16,
    parameter logic [2:0] OP_MULT = 3'b101,
    parameter logic [2:0] OP_DIV  = 3'b110
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       ALUK,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
`ifdef SLC3_MULDIV_PRODHI_EN
    ,
    output logic [WIDTH-1:0] ProdHi
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic             sign_a, sign_b, is_div, div_zero;

    logic             start_div, zero_b, accept, neg;
    logic [WIDTH-1:0] mag_a, mag_b, res_signed, rem_signed;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;

    assign start_div = (ALUK == OP_DIV);
    assign zero_b    = (B == '0);
    assign accept    = (state == IDLE) && Start && ((ALUK == OP_MULT) || start_div);
    assign mag_a     = A[WIDTH-1] ? -A : A;
    assign mag_b     = B[WIDTH-1] ? -B : B;

    // hi:lo is the running product (MULT) or remainder:quotient (DIV); opnd is
    // the multiplicand or divisor magnitude.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};

    // Low word of a negated product equals negation of the low word alone.
    assign neg        = sign_a ^ sign_b;
    assign res_signed = neg ? -lo : lo;
    assign rem_signed = sign_a ? -hi : hi;

    assign Busy = (state == CALC) || (state == FIX);
    assign Done = (state == DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (start_div && zero_b) ? FIX : CALC;
            CALC: if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_div    <= 1'b0;
            div_zero  <= 1'b0;
            Result    <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
`ifdef SLC3_MULDIV_PRODHI_EN
            ProdHi    <= '0;
`endif
        end else if (accept) begin
            cnt       <= '0;
            hi        <= '0;
            sign_a    <= A[WIDTH-1];
            sign_b    <= B[WIDTH-1];
            is_div    <= start_div;
            div_zero  <= start_div && zero_b;
            Result    <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
`ifdef SLC3_MULDIV_PRODHI_EN
            ProdHi    <= '0;
`endif
            if (start_div) begin
                // Divide-by-zero keeps raw A so it can be returned as the remainder.
                lo   <= zero_b ? A : mag_a;
                opnd <= mag_b;
            end else begin
                lo   <= mag_b;
                opnd <= mag_a;
            end
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                hi <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end else if (state == FIX) begin
            if (is_div && div_zero) begin
                Result    <= '1;
                Remainder <= lo;
                DivByZero <= 1'b1;
            end else if (is_div) begin
                Result    <= res_signed;
                Remainder <= rem_signed;
            end else begin
                Result    <= res_signed;
                Remainder <= '0;
`ifdef SLC3_MULDIV_PRODHI_EN
                ProdHi    <= neg ? (~hi + {{(WIDTH-1){1'b0}}, (lo == '0)}) : hi;
`endif
            end
        end
    end

endmodule

// File: tb/tb_slc3_muldiv_unit.sv
// Scoreboard bench for slc3_muldiv_unit: driver pushes expected results, monitor checks on Done.
// Honours SLC3_MULDIV_PRODHI_EN when the design is built with it.
module tb_slc3_muldiv_unit;

    localparam logic [2:0] MUL = 3'b101;
    localparam logic [2:0] DIV = 3'b110;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  ALUK = 3'b000;
    logic [15:0] A = '0, B = '0;
    logic        Busy, Done, DivByZero;
    logic [15:0] Result, Remainder;
`ifdef SLC3_MULDIV_PRODHI_EN
    logic [15:0] ProdHi;
`endif

    slc3_muldiv_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ALUK(ALUK), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Result(Result), .Remainder(Remainder),
        .DivByZero(DivByZero)
`ifdef SLC3_MULDIV_PRODHI_EN
        , .ProdHi(ProdHi)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [15:0] res, rem, hi;
        logic        dbz;
        int          lat, busy, acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, done_count = 0, busy_cnt = 0, dc0 = 0;
    logic        hold_chk = 1'b0;
    logic [15:0] held_res = '0;

    always @(posedge Clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_n) begin
            busy_cnt = 0;
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_result", Result, held_res);
                hold_chk = 1'b0;
            end
            if (Busy) busy_cnt++;
            if (Done) begin
                done_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, Result, e.res);
                    chk({e.name, "_remainder"}, Remainder, e.rem);
                    chk({e.name, "_divbyzero"}, DivByZero, e.dbz);
                    chk({e.name, "_latency"}, cyc - e.acc, e.lat);
                    chk({e.name, "_busy_cycles"}, busy_cnt, e.busy);
                    chk({e.name, "_busy_with_done"}, Busy, 1'b0);
`ifdef SLC3_MULDIV_PRODHI_EN
                    chk({e.name, "_prodhi"}, ProdHi, e.hi);
`endif
                    held_res = e.res;
                    hold_chk = 1'b1;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic [15:0] rem,
                         input logic dbz, input logic [15:0] hi, input bit push);
        exp_t e;
        @(negedge Clk);
        dc0 = done_count;
        Start = 1'b1; ALUK = op; A = a; B = b;
        if (push) begin
            e.name = nm; e.res = res; e.rem = rem; e.dbz = dbz; e.hi = hi;
            e.lat = dbz ? 2 : 18; e.busy = dbz ? 1 : 17; e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge Clk);
        Start = 1'b0; ALUK = 3'b000;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done_count != dc0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
        repeat (2) @(negedge Clk);
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic [15:0] rem,
                          input logic dbz, input logic [15:0] hi);
        issue(nm, op, a, b, res, rem, dbz, hi, 1'b1);
        wait_done(nm);
    endtask

    initial begin
        int dsave;
        repeat (3) @(negedge Clk);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_result", Result, 16'h0000);
        Reset_n = 1'b1;
        @(negedge Clk);

        run_op("mul_7_m3",      MUL, 16'h0007, 16'hFFFD, 16'hFFEB, 16'h0000, 1'b0, 16'hFFFF);
        run_op("div_m7_2",      DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 16'h0000);
        run_op("div_5_0",       DIV, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 16'h0000);
        run_op("mul_2_3",       MUL, 16'h0002, 16'h0003, 16'h0006, 16'h0000, 1'b0, 16'h0000);
        run_op("div_min_m1",    DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 16'h0000);
        run_op("mul_4000_4",    MUL, 16'h4000, 16'h0004, 16'h0000, 16'h0000, 1'b0, 16'h0001);
        run_op("mul_min_min",   MUL, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 16'h4000);
        run_op("mul_m1_m1",     MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000);
        run_op("mul_m5_6",      MUL, 16'hFFFB, 16'h0006, 16'hFFE2, 16'h0000, 1'b0, 16'hFFFF);
        run_op("div_100_7",     DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 16'h0000);
        run_op("div_m100_m7",   DIV, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 16'h0000);
        run_op("div_7_m100",    DIV, 16'h0007, 16'hFF9C, 16'h0000, 16'h0007, 1'b0, 16'h0000);

        // Start re-pulsed mid-operation must be ignored
        issue("mul_repulse", MUL, 16'h0123, 16'h0010, 16'h1230, 16'h0000, 1'b0, 16'h0000, 1'b1);
        repeat (2) @(negedge Clk);
        Start = 1'b1; ALUK = DIV; A = 16'h0009; B = 16'h0003;
        @(negedge Clk);
        Start = 1'b0; ALUK = 3'b000;
        wait_done("mul_repulse");

        // Non-MULT/DIV op code must not launch
        @(negedge Clk);
        Start = 1'b1; ALUK = 3'b000; A = 16'h0011; B = 16'h0022;
        @(negedge Clk);
        Start = 1'b0;
        chk("bad_aluk_busy0", Busy, 1'b0);
        repeat (2) @(negedge Clk);
        chk("bad_aluk_busy1", Busy, 1'b0);

        // Reset during CALC abandons the operation
        issue("mul_abort", MUL, 16'h0055, 16'h0033, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        repeat (7) @(negedge Clk);
        chk("abort_in_calc", Busy, 1'b1);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        chk("abort_result", Result, 16'h0000);
        chk("abort_remainder", Remainder, 16'h0000);
        chk("abort_divbyzero", DivByZero, 1'b0);
`ifdef SLC3_MULDIV_PRODHI_EN
        chk("abort_prodhi", ProdHi, 16'h0000);
`endif
        Reset_n = 1'b1;
        dsave = done_count;
        repeat (25) @(negedge Clk);
        chk("abort_no_done", done_count, dsave);

        run_op("mul_3_3", MUL, 16'h0003, 16'h0003, 16'h0009, 16'h0000, 1'b0, 16'h0000);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
